// File: rtl/gnn_top.sv
// ---------------------------------------------------------------------------
// gnn_top
//
// Purpose:
//   A fixed two-layer GCN-style inference engine for four nodes connected in a
//   ring (0-1, 1-2, 2-3, 3-0) with self-loops. Each node carries four signed
//   5-bit features.
//     layer 1 : neighbourhood sum -> 4x4 matrix multiply -> ReLU
//     layer 2 : neighbourhood sum -> 4x2 matrix multiply (linear)
//   The engine is fully pipelined. It accepts one input vector per cycle and
//   produces the matching outputs four edges after the edge that sampled them.
//   The weights travel down the pipeline with their features, so back-to-back
//   vectors may use different weight sets.
//
// Ports:
//   clk                     rising-edge clock
//   rst                     synchronous active-high reset; clears everything
//   in_ready                input valid; every x/w input is sampled when high
//   x<i>_node<n>    [4:0]   signed feature i of node n
//   w<i><k>         [4:0]   signed layer-1 weight, feature i -> hidden k (4..7)
//   w<k><j>         [4:0]   signed layer-2 weight, hidden k -> output j (8,9)
//   out0_node<n>    [20:0]  signed output unit 8 of node n
//   out1_node<n>    [20:0]  signed output unit 9 of node n
//   out10_ready_node<n>     out0_node<n> valid
//   out11_ready_node<n>     out1_node<n> valid
// ---------------------------------------------------------------------------
module gnn_top (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_ready,
  input  logic signed [4:0]  x0_node0,
  input  logic signed [4:0]  x1_node0,
  input  logic signed [4:0]  x2_node0,
  input  logic signed [4:0]  x3_node0,
  input  logic signed [4:0]  x0_node1,
  input  logic signed [4:0]  x1_node1,
  input  logic signed [4:0]  x2_node1,
  input  logic signed [4:0]  x3_node1,
  input  logic signed [4:0]  x0_node2,
  input  logic signed [4:0]  x1_node2,
  input  logic signed [4:0]  x2_node2,
  input  logic signed [4:0]  x3_node2,
  input  logic signed [4:0]  x0_node3,
  input  logic signed [4:0]  x1_node3,
  input  logic signed [4:0]  x2_node3,
  input  logic signed [4:0]  x3_node3,
  input  logic signed [4:0]  w04,
  input  logic signed [4:0]  w14,
  input  logic signed [4:0]  w24,
  input  logic signed [4:0]  w34,
  input  logic signed [4:0]  w05,
  input  logic signed [4:0]  w15,
  input  logic signed [4:0]  w25,
  input  logic signed [4:0]  w35,
  input  logic signed [4:0]  w06,
  input  logic signed [4:0]  w16,
  input  logic signed [4:0]  w26,
  input  logic signed [4:0]  w36,
  input  logic signed [4:0]  w07,
  input  logic signed [4:0]  w17,
  input  logic signed [4:0]  w27,
  input  logic signed [4:0]  w37,
  input  logic signed [4:0]  w48,
  input  logic signed [4:0]  w58,
  input  logic signed [4:0]  w68,
  input  logic signed [4:0]  w78,
  input  logic signed [4:0]  w49,
  input  logic signed [4:0]  w59,
  input  logic signed [4:0]  w69,
  input  logic signed [4:0]  w79,
  output logic signed [20:0] out0_node0,
  output logic signed [20:0] out0_node1,
  output logic signed [20:0] out0_node2,
  output logic signed [20:0] out0_node3,
  output logic signed [20:0] out1_node0,
  output logic signed [20:0] out1_node1,
  output logic signed [20:0] out1_node2,
  output logic signed [20:0] out1_node3,
  output logic               out10_ready_node0,
  output logic               out10_ready_node1,
  output logic               out10_ready_node2,
  output logic               out10_ready_node3,
  output logic               out11_ready_node0,
  output logic               out11_ready_node1,
  output logic               out11_ready_node2,
  output logic               out11_ready_node3
);

  // -------------------------------------------------------------------------
  // Array views of the flat input ports
  //   w_x  [node][feature]
  //   w_w1 [hidden k-4][feature]
  //   w_w2 [output j-8][hidden k-4]
  // -------------------------------------------------------------------------
  logic signed [4:0] w_x  [4][4];
  logic signed [4:0] w_w1 [4][4];
  logic signed [4:0] w_w2 [2][4];

  assign w_x[0] = '{x0_node0, x1_node0, x2_node0, x3_node0};
  assign w_x[1] = '{x0_node1, x1_node1, x2_node1, x3_node1};
  assign w_x[2] = '{x0_node2, x1_node2, x2_node2, x3_node2};
  assign w_x[3] = '{x0_node3, x1_node3, x2_node3, x3_node3};

  assign w_w1[0] = '{w04, w14, w24, w34};
  assign w_w1[1] = '{w05, w15, w25, w35};
  assign w_w1[2] = '{w06, w16, w26, w36};
  assign w_w1[3] = '{w07, w17, w27, w37};

  assign w_w2[0] = '{w48, w58, w68, w78};
  assign w_w2[1] = '{w49, w59, w69, w79};

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  // stage 0: raw inputs
  logic signed [4:0]  r_x     [4][4];
  logic signed [4:0]  r_w1_s0 [4][4];
  logic signed [4:0]  r_w2_s0 [2][4];
  logic               r_valid0;
  // stage 1: first aggregation
  logic signed [6:0]  r_a     [4][4];
  logic signed [4:0]  r_w1_s1 [4][4];
  logic signed [4:0]  r_w2_s1 [2][4];
  logic               r_valid1;
  // stage 2: hidden activations after ReLU (always >= 0)
  logic signed [13:0] r_h     [4][4];
  logic signed [4:0]  r_w2_s2 [2][4];
  logic               r_valid2;
  // stage 3: second aggregation
  logic signed [15:0] r_g     [4][4];
  logic signed [4:0]  r_w2_s3 [2][4];
  logic               r_valid3;
  // stage 4: outputs [output][node]
  logic signed [20:0] r_out   [2][4];
  logic               r_valid4;

  // Combinational next values for each stage
  logic signed [6:0]  w_a_next   [4][4];
  logic signed [13:0] w_h_next   [4][4];
  logic signed [15:0] w_g_next   [4][4];
  logic signed [20:0] w_out_next [2][4];

  // -------------------------------------------------------------------------
  // Per-node datapath. On the ring every neighbourhood is {prev, self, next},
  // which matches N(0)={3,0,1}, N(1)={0,1,2}, N(2)={1,2,3}, N(3)={2,3,0}.
  // Size casts on signed operands sign-extend, so each sum is formed at its
  // full result width and cannot overflow.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_node
      localparam int PREV = (gi + 3) % 4;
      localparam int NEXT = (gi + 1) % 4;

      // first aggregation: 3 x 5-bit -> 7-bit
      for (genvar gf = 0; gf < 4; gf++) begin : g_agg1
        assign w_a_next[gi][gf] = 7'(r_x[PREV][gf]) + 7'(r_x[gi][gf])
                                + 7'(r_x[NEXT][gf]);
      end

      // layer 1: 7x5 products fit in 12 bits, four of them in 14 bits
      for (genvar gk = 0; gk < 4; gk++) begin : g_hid
        logic signed [11:0] w_prod [4];
        logic signed [13:0] w_sum;
        for (genvar gf = 0; gf < 4; gf++) begin : g_mul
          assign w_prod[gf] = 12'(r_a[gi][gf]) * 12'(r_w1_s1[gk][gf]);
        end
        assign w_sum = 14'(w_prod[0]) + 14'(w_prod[1])
                     + 14'(w_prod[2]) + 14'(w_prod[3]);
        // ReLU is per node, before the neighbours are summed again
        assign w_h_next[gi][gk] = w_sum[13] ? 14'sd0 : w_sum;
      end

      // second aggregation over the (non-negative) hidden units
      for (genvar gk = 0; gk < 4; gk++) begin : g_agg2
        assign w_g_next[gi][gk] = 16'(r_h[PREV][gk]) + 16'(r_h[gi][gk])
                                + 16'(r_h[NEXT][gk]);
      end

      // layer 2: linear, worst case |589824| fits in 21 bits
      for (genvar gj = 0; gj < 2; gj++) begin : g_out
        logic signed [20:0] w_prod [4];
        for (genvar gk = 0; gk < 4; gk++) begin : g_mul
          assign w_prod[gk] = 21'(r_g[gi][gk]) * 21'(r_w2_s3[gj][gk]);
        end
        assign w_out_next[gj][gi] = w_prod[0] + w_prod[1]
                                  + w_prod[2] + w_prod[3];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Pipeline state. The valid bits always shift; each data stage loads only
  // when the valid bit feeding it is set and otherwise holds, which is what
  // keeps the outputs stable while no new vector is arriving.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
      r_valid3 <= 1'b0;
      r_valid4 <= 1'b0;
      r_x      <= '{default: '0};
      r_w1_s0  <= '{default: '0};
      r_w2_s0  <= '{default: '0};
      r_a      <= '{default: '0};
      r_w1_s1  <= '{default: '0};
      r_w2_s1  <= '{default: '0};
      r_h      <= '{default: '0};
      r_w2_s2  <= '{default: '0};
      r_g      <= '{default: '0};
      r_w2_s3  <= '{default: '0};
      r_out    <= '{default: '0};
    end else begin
      r_valid0 <= in_ready;
      r_valid1 <= r_valid0;
      r_valid2 <= r_valid1;
      r_valid3 <= r_valid2;
      r_valid4 <= r_valid3;
      if (in_ready) begin
        r_x     <= w_x;
        r_w1_s0 <= w_w1;
        r_w2_s0 <= w_w2;
      end
      if (r_valid0) begin
        r_a     <= w_a_next;
        r_w1_s1 <= r_w1_s0;
        r_w2_s1 <= r_w2_s0;
      end
      if (r_valid1) begin
        r_h     <= w_h_next;
        r_w2_s2 <= r_w2_s1;
      end
      if (r_valid2) begin
        r_g     <= w_g_next;
        r_w2_s3 <= r_w2_s2;
      end
      if (r_valid3) begin
        r_out   <= w_out_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out0_node0 = r_out[0][0];
  assign out0_node1 = r_out[0][1];
  assign out0_node2 = r_out[0][2];
  assign out0_node3 = r_out[0][3];
  assign out1_node0 = r_out[1][0];
  assign out1_node1 = r_out[1][1];
  assign out1_node2 = r_out[1][2];
  assign out1_node3 = r_out[1][3];

  // every output shares the same stage-4 valid bit
  assign out10_ready_node0 = r_valid4;
  assign out10_ready_node1 = r_valid4;
  assign out10_ready_node2 = r_valid4;
  assign out10_ready_node3 = r_valid4;
  assign out11_ready_node0 = r_valid4;
  assign out11_ready_node1 = r_valid4;
  assign out11_ready_node2 = r_valid4;
  assign out11_ready_node3 = r_valid4;

endmodule

// File: tb/tb_gnn_top.sv
// ---------------------------------------------------------------------------
// tb_gnn_top
//
// Purpose:
//   Self-checking bench for gnn_top. Each accepted input vector pushes the
//   reference model's eight outputs, tagged with the cycle they are due, onto
//   a scoreboard queue. Every cycle the ready flags are compared with whether
//   an entry is due. When one is due it is popped and becomes the value the
//   outputs must show. Otherwise the outputs must hold the last value.
//   Directed checks against hand-derived constants are added after the key
//   vectors.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_gnn_top;

  typedef struct packed {
    int               due;
    logic [7:0][20:0] o;   // index j*4 + n
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic in_ready;
  logic signed [4:0] tx  [4][4];   // [node][feature]
  logic signed [4:0] tw1 [4][4];   // [hidden k-4][feature]
  logic signed [4:0] tw2 [2][4];   // [output j-8][hidden k-4]
  wire  signed [20:0] act [8];     // out0_node0..3, out1_node0..3
  wire  [7:0] rdy;                 // out10_ready_node0..3, out11_ready_node0..3

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb [$];
  logic [7:0][20:0] held = '0;

  always #5 clk = ~clk;

  gnn_top dut (
    .clk(clk), .rst(rst), .in_ready(in_ready),
    .x0_node0(tx[0][0]), .x1_node0(tx[0][1]), .x2_node0(tx[0][2]), .x3_node0(tx[0][3]),
    .x0_node1(tx[1][0]), .x1_node1(tx[1][1]), .x2_node1(tx[1][2]), .x3_node1(tx[1][3]),
    .x0_node2(tx[2][0]), .x1_node2(tx[2][1]), .x2_node2(tx[2][2]), .x3_node2(tx[2][3]),
    .x0_node3(tx[3][0]), .x1_node3(tx[3][1]), .x2_node3(tx[3][2]), .x3_node3(tx[3][3]),
    .w04(tw1[0][0]), .w14(tw1[0][1]), .w24(tw1[0][2]), .w34(tw1[0][3]),
    .w05(tw1[1][0]), .w15(tw1[1][1]), .w25(tw1[1][2]), .w35(tw1[1][3]),
    .w06(tw1[2][0]), .w16(tw1[2][1]), .w26(tw1[2][2]), .w36(tw1[2][3]),
    .w07(tw1[3][0]), .w17(tw1[3][1]), .w27(tw1[3][2]), .w37(tw1[3][3]),
    .w48(tw2[0][0]), .w58(tw2[0][1]), .w68(tw2[0][2]), .w78(tw2[0][3]),
    .w49(tw2[1][0]), .w59(tw2[1][1]), .w69(tw2[1][2]), .w79(tw2[1][3]),
    .out0_node0(act[0]), .out0_node1(act[1]), .out0_node2(act[2]), .out0_node3(act[3]),
    .out1_node0(act[4]), .out1_node1(act[5]), .out1_node2(act[6]), .out1_node3(act[7]),
    .out10_ready_node0(rdy[0]), .out10_ready_node1(rdy[1]),
    .out10_ready_node2(rdy[2]), .out10_ready_node3(rdy[3]),
    .out11_ready_node0(rdy[4]), .out11_ready_node1(rdy[5]),
    .out11_ready_node2(rdy[6]), .out11_ready_node3(rdy[7])
  );

  // Reference model written directly from the neighbourhood table
  function automatic logic [7:0][20:0] model();
    int nb [4][3];
    int a [4][4];
    int h [4][4];
    int g [4][4];
    int s;
    logic [7:0][20:0] r;
    nb = '{'{0, 1, 3}, '{0, 1, 2}, '{1, 2, 3}, '{0, 2, 3}};
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) begin
        a[n][i] = 0;
        for (int m = 0; m < 3; m++) a[n][i] += int'(tx[nb[n][m]][i]);
      end
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++) begin
        s = 0;
        for (int i = 0; i < 4; i++) s += a[n][i] * int'(tw1[k][i]);
        h[n][k] = (s < 0) ? 0 : s;
      end
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++) begin
        g[n][k] = 0;
        for (int m = 0; m < 3; m++) g[n][k] += h[nb[n][m]][k];
      end
    for (int j = 0; j < 2; j++)
      for (int n = 0; n < 4; n++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += g[n][k] * int'(tw2[j][k]);
        r[j*4 + n] = 21'(s);
      end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic signed [20:0] obs,
                           input logic signed [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_bits(input string tag, input logic [7:0] obs,
                            input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: scoreboard push at the edge, compare 1 time unit later
  task automatic step();
    exp_t e;
    logic exp_ready;
    @(posedge clk);
    cyc++;
    if (rst) begin
      sb.delete();
      held = '0;
    end else if (in_ready) begin
      e.o = model();
      e.due = cyc + 4;
      sb.push_back(e);
    end
    #1;
    exp_ready = (sb.size() > 0) && (sb[0].due == cyc);
    check_bits($sformatf("ready_c%0d", cyc), rdy, {8{exp_ready}});
    if (exp_ready) begin
      e = sb.pop_front();
      held = e.o;
    end
    for (int k = 0; k < 8; k++)
      check_val($sformatf("out%0d_node%0d_c%0d", k / 4, k % 4, cyc), act[k], held[k]);
    $display("cycle %0d rst=%0b in_ready=%0b ready=%b out0=(%0d,%0d,%0d,%0d) out1=(%0d,%0d,%0d,%0d)",
             cyc, rst, in_ready, rdy, act[0], act[1], act[2], act[3],
             act[4], act[5], act[6], act[7]);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_all(input int v);
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) begin
        tx[n][i]  = 5'(v);
        tw1[n][i] = 5'(v);
      end
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++) tw2[j][k] = 5'(v);
  endtask

  task automatic set_rand();
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) begin
        tx[n][i]  = 5'($urandom_range(0, 31));
        tw1[n][i] = 5'($urandom_range(0, 31));
      end
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++) tw2[j][k] = 5'($urandom_range(0, 31));
  endtask

  task automatic set_t2();
    int vx [4][4];
    int v1 [4][4];
    int v2 [2][4];
    vx = '{'{4, 2, 4, 1}, '{6, 4, 4, 1}, '{8, 6, 4, 1}, '{6, 4, 4, 1}};
    v1 = '{'{3, 2, 13, -6}, '{-9, 1, -4, 14}, '{3, 6, -15, 15}, '{9, -10, 15, -10}};
    v2 = '{'{0, -1, 3, -11}, '{-12, -15, -15, 6}};
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) begin
        tx[n][i]  = 5'(vx[n][i]);
        tw1[n][i] = 5'(v1[n][i]);
      end
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++) tw2[j][k] = 5'(v2[j][k]);
  endtask

  task automatic check_const(input string tag, input int e0 [4], input int e1 [4]);
    for (int n = 0; n < 4; n++) begin
      check_val($sformatf("%s_out0_node%0d", tag, n), act[n], 21'(e0[n]));
      check_val($sformatf("%s_out1_node%0d", tag, n), act[4 + n], 21'(e1[n]));
    end
    check_bits({tag, "_ready"}, rdy, 8'hFF);
  endtask

  initial begin
    int e0 [4];
    int e1 [4];

    // T1: reset with in_ready high, T2 vector already on the inputs
    rst = 1'b1;
    in_ready = 1'b1;
    set_t2();
    steps(2);

    // T2: first result appears on the 5th edge counted from release
    rst = 1'b0;
    steps(4);
    check_bits("t1_no_early_ready", rdy, 8'h00);
    step();
    e0 = '{-6358, -6309, -6287, -6309};
    e1 = '{-4188, -4455, -4587, -4455};
    check_const("t2", e0, e1);
    check_val("t2_node1_eq_node3", act[1], act[3]);

    // T3: all inputs at the minimum
    set_all(-16);
    steps(5);
    e0 = '{-589824, -589824, -589824, -589824};
    check_const("t3", e0, e0);

    // T4: all inputs at the maximum
    set_all(15);
    steps(5);
    e0 = '{486000, 486000, 486000, 486000};
    check_const("t4", e0, e0);

    // T5: in_ready low for 20 cycles with changing inputs, then re-raise
    in_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_rand();
      step();
    end
    check_val("t5_hold_out0_node0", act[0], 21'sd486000);
    check_val("t5_hold_out1_node3", act[7], 21'sd486000);
    in_ready = 1'b1;
    set_rand();
    step();
    in_ready = 1'b0;
    steps(6);

    // random vectors, back to back and with gaps in in_ready
    for (int i = 0; i < 16; i++) begin
      in_ready = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      set_rand();
      step();
    end
    in_ready = 1'b0;
    steps(5);

    // T6: alternate minimum and maximum vectors every cycle
    in_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_all((i % 2 == 0) ? -16 : 15);
      step();
    end
    in_ready = 1'b0;
    steps(4);
    check_val("t6_last_out0_node2", act[2], 21'sd486000);

    // reset in the middle of the pipeline discards in-flight vectors
    in_ready = 1'b1;
    set_t2();
    steps(2);
    rst = 1'b1;
    set_all(15);
    step();
    rst = 1'b0;
    in_ready = 1'b0;
    steps(6);
    check_bits("midreset_ready", rdy, 8'h00);
    check_val("midreset_out0_node0", act[0], 21'sd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
